// File: rtl/multi_sel_feeder.sv
// Show-ahead sample FIFO feeding multi_sel: valid/ready on the producer side,
// grant-pulse consumption on the multi_sel side, sticky underrun flag.
module multi_sel_feeder #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          input_grant,
  output logic [0:7]    d,
  output logic          d_valid,
  output logic [AW:0]   level,
  input  logic          flush,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    last_q, last_d;
  logic          underrun_q, underrun_d;
  logic          push, pop;

  assign d_valid  = (level_q != '0);
  assign in_ready = (level_q != FULL_LEVEL);
  assign level    = level_q;
  assign underrun = underrun_q;
  // Head is read straight from storage; last_q only matters once the queue drains.
  assign d        = d_valid ? mem[rd_ptr_q] : last_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = input_grant && d_valid && !flush;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    underrun_d = (underrun_q && !underrun_clr) ||
                 (input_grant && !d_valid && !flush);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      last_d   = 8'h00;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        last_d   = mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: storage is deliberately not reset; level gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_multi_sel_feeder.sv
// Directed bench for multi_sel_feeder: vector table for single-cycle behaviour,
// hand sequences for full/backpressure, scoreboarded streaming and async reset.
module tb_multi_sel_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       input_grant;
  logic [0:7] d;
  logic       d_valid;
  logic [3:0] level;
  logic       flush;
  logic       underrun;
  logic       underrun_clr;

  int checks   = 0;
  int failures = 0;

  multi_sel_feeder #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_grant  (input_grant),
    .d            (d),
    .d_valid      (d_valid),
    .level        (level),
    .flush        (flush),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] din;
    logic       g;
    logic       f;
    logic       uc;
    logic [3:0] lvl;
    logic [7:0] dq;
    logic       dv;
    logic       rdy;
    logic       ur;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] din, input logic g,
                       input logic f, input logic uc);
    in_valid     = v;
    in_data      = din;
    input_grant  = g;
    flush        = f;
    underrun_clr = uc;
  endtask

  // Packed view {level, d, d_valid, in_ready, underrun}
  function automatic logic [31:0] outs();
    return {17'd0, level, d, d_valid, in_ready, underrun};
  endfunction

  function automatic logic [31:0] exp_outs(input logic [3:0] l, input logic [7:0] dq,
                                           input logic dv, input logic rdy, input logic ur);
    return {17'd0, l, dq, dv, rdy, ur};
  endfunction

  logic [7:0] q[$];
  logic [7:0] next_val;
  int         pops;
  logic       push_ok;

  initial begin
    //            v  din    g  f  uc   lvl dq     dv rdy ur
    tbl[0]  = '{1, 8'hA5, 0, 0, 0,   1, 8'hA5, 1, 1, 0};
    tbl[1]  = '{1, 8'h3C, 0, 0, 0,   2, 8'hA5, 1, 1, 0};
    tbl[2]  = '{1, 8'h81, 0, 0, 0,   3, 8'hA5, 1, 1, 0};
    tbl[3]  = '{0, 8'h00, 0, 0, 0,   3, 8'hA5, 1, 1, 0};
    tbl[4]  = '{0, 8'h00, 1, 0, 0,   2, 8'h3C, 1, 1, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 0,   1, 8'h81, 1, 1, 0};
    tbl[6]  = '{0, 8'h00, 1, 0, 0,   0, 8'h81, 0, 1, 0};
    tbl[7]  = '{0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 1, 0};
    tbl[8]  = '{0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 1, 1};
    tbl[9]  = '{1, 8'h7E, 1, 0, 0,   1, 8'h7E, 1, 1, 1};
    tbl[10] = '{0, 8'h00, 0, 0, 1,   1, 8'h7E, 1, 1, 0};
    tbl[11] = '{0, 8'h00, 1, 0, 1,   0, 8'h7E, 0, 1, 0};
    tbl[12] = '{0, 8'h00, 1, 0, 1,   0, 8'h7E, 0, 1, 1};
    tbl[13] = '{1, 8'h01, 0, 0, 0,   1, 8'h01, 1, 1, 1};
    tbl[14] = '{1, 8'h02, 0, 0, 0,   2, 8'h01, 1, 1, 1};
    tbl[15] = '{1, 8'h03, 0, 0, 0,   3, 8'h01, 1, 1, 1};
    tbl[16] = '{1, 8'h04, 0, 0, 0,   4, 8'h01, 1, 1, 1};
    tbl[17] = '{1, 8'h05, 0, 0, 0,   5, 8'h01, 1, 1, 1};
    tbl[18] = '{1, 8'h99, 1, 1, 0,   0, 8'h00, 0, 1, 1};
    tbl[19] = '{0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 1, 1};
    tbl[20] = '{0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 1, 0};
    tbl[21] = '{1, 8'h55, 1, 0, 0,   1, 8'h55, 1, 1, 1};
    tbl[22] = '{0, 8'h00, 1, 0, 0,   0, 8'h55, 0, 1, 1};
    tbl[23] = '{0, 8'h00, 0, 0, 1,   0, 8'h55, 0, 1, 0};

    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    #1;
    check("reset_outputs", outs(), exp_outs(0, 8'h00, 0, 1, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #4;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].din, tbl[i].g, tbl[i].f, tbl[i].uc);
      tick();
      drive(0, 8'h00, 0, 0, 0);
      check($sformatf("vec%0d", i), outs(),
            exp_outs(tbl[i].lvl, tbl[i].dq, tbl[i].dv, tbl[i].rdy, tbl[i].ur));
    end

    // Fill to full, then hold a pending sample against backpressure.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      tick();
    end
    drive(1, 8'h09, 0, 0, 0);
    check("full_state", outs(), exp_outs(8, 8'h01, 1, 0, 0));
    tick();
    check("full_hold", outs(), exp_outs(8, 8'h01, 1, 0, 0));
    drive(1, 8'h09, 1, 0, 0);
    tick();
    drive(1, 8'h09, 0, 0, 0);
    check("full_pop", outs(), exp_outs(7, 8'h02, 1, 1, 0));
    tick();
    drive(0, 8'h00, 0, 0, 0);
    check("refill", outs(), exp_outs(8, 8'h02, 1, 0, 0));
    // Back-to-back grants drain in order.
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("drain_d%0d", i), 32'(d), 32'(i));
      drive(0, 8'h00, 1, 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    check("drained", outs(), exp_outs(0, 8'h09, 0, 1, 0));

    // Continuous producer, grant every 4th cycle, scoreboarded across wraps.
    q.delete();
    next_val = 8'h10;
    pops = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      drive(1, next_val, (cyc % 4) == 3, 0, 0);
      check("sb_ready", 32'(in_ready), 32'(q.size() != 8));
      check("sb_valid", 32'(d_valid), 32'(q.size() != 0));
      push_ok = (q.size() != 8);
      if (input_grant && q.size() != 0) begin
        check($sformatf("sb_pop%0d", pops), 32'(d), 32'(q[0]));
        void'(q.pop_front());
        pops++;
      end
      if (push_ok) begin
        q.push_back(next_val);
        next_val = next_val + 8'd1;
      end
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    check("sb_level", 32'(level), 32'(q.size()));
    check("sb_pop_count", 32'(pops >= 24), 32'd1);

    // Asynchronous reset between edges with data queued.
    drive(0, 8'h00, 0, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hE0 + 8'(i), 0, 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    check("pre_reset", outs(), exp_outs(4, 8'hE0, 1, 1, 0));
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", outs(), exp_outs(0, 8'h00, 0, 1, 0));
    #2;
    rst = 1'b1;
    // First cycle after release: push plus a grant on an empty FIFO.
    drive(1, 8'hC3, 1, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    check("post_reset_push", outs(), exp_outs(1, 8'hC3, 1, 1, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_sel_feeder.md
Name: multi_sel_feeder

Overview:
- Input-side stage that sits directly upstream of multi_sel.
- Accepts 8-bit samples from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head sample on d; multi_sel drives input_grant to consume it.
- Decouples bursty producers from multi_sel's fixed 4-cycle sampling cadence and flags underrun when multi_sel samples with nothing queued.

Parameters:
- DEPTH, 8, FIFO capacity in samples; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_data  input  8  producer sample.
- in_valid  input  1  producer has a sample on in_data.
- in_ready  output  1  feeder can accept a sample this cycle.
- input_grant  input  1  from multi_sel; one-cycle pulse meaning "d sampled this cycle".
- d  output  [0:7]  head sample to multi_sel; bit 0 is MSB.
- d_valid  output  1  d holds an unconsumed queued sample.
- level  output  AW+1  number of queued samples, 0..DEPTH.
- flush  input  1  synchronous clear of FIFO contents.
- underrun  output  1  sticky: a grant arrived while empty.
- underrun_clr  input  1  synchronous clear of underrun.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values (rst low, asynchronous): level=0, read/write pointers=0, d=8'h00, d_valid=0, underrun=0, in_ready=1. Storage contents are don't-care.
- Push: occurs when in_valid && in_ready at a rising edge. in_ready = (level != DEPTH), computed combinationally from registered level only; it never depends on in_valid or input_grant.
- Pop: occurs when input_grant && d_valid at a rising edge.
- Pop handover: after a pop, d shows the next entry in the following cycle, or holds the popped value if the FIFO is now empty.
- Show-ahead timing:
  - When d_valid=1, d equals the oldest queued sample with zero read latency.
  - A push into an empty FIFO makes d_valid=1 and d=sample on the cycle after the push edge.
- Empty hold: when d_valid=0, d holds the last popped value (8'h00 if nothing has been popped since reset or flush).
- Level update per edge: level += push − pop.
  - Simultaneous push and pop leaves level unchanged and keeps FIFO order.
  - Full with a pop and in_valid high: in_ready=0 that cycle, so the push is not taken; in_ready returns to 1 the next cycle.
- Underrun:
  - input_grant while d_valid=0 sets underrun=1 and pops nothing; level stays 0.
  - A push in the same cycle is still stored normally and is not consumed by that grant.
- underrun_clr: clears underrun at the next edge. If an underrun event occurs in the same cycle, set wins and underrun stays 1.
- flush (synchronous, highest priority over push/pop):
  - Pointers and level go to 0, d_valid=0, d=8'h00.
  - A push or grant in the flush cycle is discarded; the grant does not set underrun.
  - underrun is not affected by flush.
- Pointer wrap: pointers wrap from DEPTH−1 to 0 naturally. Full/empty are decided by level, not by pointer compare.
- Grant timing: multi_sel issues input_grant at most once per 4 cycles. The feeder must nevertheless tolerate back-to-back grants (one pop per cycle) and a grant asserted on the first cycle after reset release.
- Reset mid-operation: all queued data is lost and the outputs return to their reset values immediately, asynchronously.

Test Plan:
- Reset, then push 8'hA5, 8'h3C, 8'h81 on consecutive cycles with no grant -> level=3, d=8'hA5, d_valid=1, in_ready=1; grant pulse -> next cycle d=8'h3C, level=2.
- Fill DEPTH=8 with 8'h01..8'h08, hold in_valid with 8'h09 -> in_ready=0 and level=8. Grant once -> level=7 and d=8'h02; 8'h09 is accepted the following cycle and level returns to 8.
- Empty FIFO, grant pulse -> underrun=1, level=0, d=8'h00. Push 8'h7E and grant in the same cycle -> underrun stays 1, level=1, d=8'h7E. Assert underrun_clr -> underrun=0.
- Steady push every cycle with grant every 4th cycle until full -> pops occur in push order with no loss or duplication; a scoreboard compares the sequence of d values at grant edges against the pushed sequence across at least 3 pointer wraps.
- Level=5, assert flush with in_valid and input_grant high -> level=0, d_valid=0, d=8'h00, underrun unchanged, pushed sample discarded.
- Level=4, drive rst low between clock edges -> all outputs at reset values before the next edge; after release, first push 8'hC3 appears on d one cycle later.
